// File: rtl/joystick_scanner.sv
// Scans two daisy-chained 74HC165s for the DB9 joysticks and returns debounced,
// active-high button states. All sequencing is paced by the ce tick.
module joystick_scanner #(
    parameter int GAP = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       joyD,
    output logic       joyLd,
    output logic       joyCk,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       scan_done
);

    typedef enum logic [2:0] {
        LOAD,
        LATCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE,
        IDLE
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'((GAP == 0) ? 0 : GAP - 1);

    state_t      state;
    logic [3:0]  k;
    logic [7:0]  g;
    logic [15:0] raw;
    logic [15:0] prev;
    logic [7:0]  raw_j1;
    logic [7:0]  raw_j2;

    // Chain order is reversed relative to the joystick bit map within each byte.
    always_comb begin
        raw_j1 = '0;
        raw_j2 = '0;
        for (int i = 0; i < 8; i++) begin
            raw_j1[7-i] = raw[i];
            raw_j2[7-i] = raw[8+i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            k         <= '0;
            g         <= '0;
            raw       <= '0;
            prev      <= '0;
            joyLd     <= 1'b1;
            joyCk     <= 1'b0;
            joy1      <= '0;
            joy2      <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (ce) begin
                case (state)
                    LOAD: begin
                        joyLd <= 1'b0;
                        joyCk <= 1'b0;
                        k     <= '0;
                        state <= LATCH;
                    end
                    LATCH: begin
                        joyLd <= 1'b1;
                        state <= SHIFT_LO;
                    end
                    SHIFT_LO: begin
                        raw[k] <= ~joyD;
                        joyCk  <= 1'b1;
                        state  <= SHIFT_HI;
                    end
                    SHIFT_HI: begin
                        joyCk <= 1'b0;
                        if (k == 4'd15) begin
                            state <= DONE;
                        end else begin
                            k     <= k + 4'd1;
                            state <= SHIFT_LO;
                        end
                    end
                    DONE: begin
                        // Only publish a pattern seen on two consecutive scans.
                        if (raw == prev) begin
                            joy1 <= raw_j1;
                            joy2 <= raw_j2;
                        end
                        prev      <= raw;
                        scan_done <= 1'b1;
                        g         <= '0;
                        state     <= (GAP == 0) ? LOAD : IDLE;
                    end
                    IDLE: begin
                        if (g == GAP_LAST) state <= LOAD;
                        else               g     <= g + 8'd1;
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joystick_scanner.sv
// Bench: two scanners (GAP=64 at ce=clock/2, GAP=0 at stalled 1/4 rate) driven
// by a 74HC165 chain model and checked against a scan-level debounce model.
module tb_joystick_scanner;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  ce      = '0;
    logic [1:0]  joyD;
    logic [1:0]  joyLd;
    logic [1:0]  joyCk;
    logic [1:0]  scan_done;
    logic [7:0]  joy1 [2];
    logic [7:0]  joy2 [2];

    logic [15:0] pressed [2];
    logic [15:0] sr [2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] lp [2] = '{16'h0000, 16'h0000};
    logic [1:0]  ckd = '0;
    int unsigned ticks [2] = '{0, 0};
    int          scan_len [2] = '{99, 35};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] p;
        logic [7:0]  j1;
        logic [7:0]  j2;
    } vec_t;
    vec_t tbl [13];

    joystick_scanner #(.GAP(64)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce[0]), .joyD(joyD[0]),
        .joyLd(joyLd[0]), .joyCk(joyCk[0]), .joy1(joy1[0]), .joy2(joy2[0]),
        .scan_done(scan_done[0])
    );

    joystick_scanner #(.GAP(0)) dut_nogap (
        .clock(clock), .reset_n(reset_n), .ce(ce[1]), .joyD(joyD[1]),
        .joyLd(joyLd[1]), .joyCk(joyCk[1]), .joy1(joy1[1]), .joy2(joy2[1]),
        .scan_done(scan_done[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] map_out(input logic [15:0] p);
        logic [7:0] j1;
        logic [7:0] j2;
        j1 = '0;
        j2 = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < 8) j1[7-b]  = p[b];
            else       j2[15-b] = p[b];
        end
        return {j1, j2};
    endfunction

    // 74HC165 chain: parallel load while LD low, shift toward joyD on CK rise.
    assign joyD[0] = sr[0][0];
    assign joyD[1] = sr[1][0];
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!joyLd[i]) begin
                sr[i] <= ~pressed[i];
                lp[i] <= pressed[i];
            end else if (joyCk[i] && !ckd[i]) begin
                sr[i] <= {1'b1, sr[i][15:1]};
            end
            ckd[i] <= joyCk[i];
        end
    end

    always @(posedge clock)
        for (int i = 0; i < 2; i++)
            if (reset_n && ce[i]) ticks[i] <= ticks[i] + 1;

    // Scan-level monitor and debounce reference.
    logic [15:0] m_prev [2];
    logic [15:0] m_exp [2];
    logic [7:0]  l1 [2];
    logic [7:0]  l2 [2];
    int          ckn [2];
    int          ldn [2];
    int unsigned t_last [2];
    int unsigned t_ld [2];
    int unsigned t_ck [2];
    bit          first [2];
    logic [1:0]  ldp = 2'b11;
    logic [1:0]  ckp = 2'b00;
    logic [1:0]  sdp = 2'b00;

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_prev[i] = '0;
                m_exp[i]  = '0;
                ckn[i]    = 0;
                ldn[i]    = 0;
                t_last[i] = ticks[i];
                first[i]  = 1'b1;
            end else begin
                if (ldp[i] && !joyLd[i]) begin ldn[i]++; t_ld[i] = ticks[i]; end
                if (!ldp[i] && joyLd[i]) chk("ld_low_ticks", ticks[i] - t_ld[i], 1);
                if (!ckp[i] && joyCk[i]) begin ckn[i]++; t_ck[i] = ticks[i]; end
                if (ckp[i] && !joyCk[i]) chk("ck_high_ticks", ticks[i] - t_ck[i], 1);
                if (!scan_done[i]) begin
                    chk("joy_hold", {joy1[i], joy2[i]}, {l1[i], l2[i]});
                end else begin
                    chk("scan_done_width", sdp[i], 0);
                    chk("ck_pulses", ckn[i], 16);
                    chk("ld_pulses", ldn[i], 1);
                    chk("scan_ticks", ticks[i] - t_last[i], first[i] ? 35 : scan_len[i]);
                    if (lp[i] == m_prev[i]) m_exp[i] = map_out(lp[i]);
                    m_prev[i] = lp[i];
                    chk("model_joy", {joy1[i], joy2[i]}, m_exp[i]);
                    ckn[i]    = 0;
                    ldn[i]    = 0;
                    t_last[i] = ticks[i];
                    first[i]  = 1'b0;
                end
            end
            ldp[i] = joyLd[i];
            ckp[i] = joyCk[i];
            sdp[i] = scan_done[i];
            l1[i]  = joy1[i];
            l2[i]  = joy2[i];
        end
    end

    // ce: instance 0 every other clock, instance 1 at 1/4 rate with random stalls.
    initial begin
        int phase = 0;
        forever begin
            @(negedge clock);
            ce[0] = ~ce[0];
            phase++;
            ce[1] = ((phase % 4) == 0) && ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_done(input int i, input string name);
        int n = 0;
        @(negedge clock);
        while (!scan_done[i] && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk(name, scan_done[i], 1);
    endtask

    initial begin
        tbl[0]  = '{16'h0000, 8'h00, 8'h00};
        tbl[1]  = '{16'h0010, 8'h00, 8'h00};
        tbl[2]  = '{16'h0000, 8'h00, 8'h00};
        tbl[3]  = '{16'h0000, 8'h00, 8'h00};
        tbl[4]  = '{16'h0480, 8'h00, 8'h00};
        tbl[5]  = '{16'h0480, 8'h01, 8'h20};
        tbl[6]  = '{16'h0480, 8'h01, 8'h20};
        tbl[7]  = '{16'h0001, 8'h01, 8'h20};
        tbl[8]  = '{16'h0001, 8'h80, 8'h00};
        tbl[9]  = '{16'h8000, 8'h80, 8'h00};
        tbl[10] = '{16'h8000, 8'h00, 8'h01};
        tbl[11] = '{16'hFFFF, 8'h00, 8'h01};
        tbl[12] = '{16'hFFFF, 8'hFF, 8'hFF};

        pressed[0] = '0;
        pressed[1] = '0;

        // Reset held with ce toggling.
        repeat (4) begin
            @(negedge clock);
            chk("rst_joyLd", joyLd[0], 1);
            chk("rst_joyCk", joyCk[0], 0);
            chk("rst_joy", {joy1[0], joy2[0]}, 0);
            chk("rst_scan_done", scan_done[0], 0);
        end
        reset_n = 1'b1;
        begin
            int n = 0;
            @(posedge clock); #1;
            while (!ce[0] && n < 10) begin
                chk("ld_before_tick", joyLd[0], 1);
                @(posedge clock); #1;
                n++;
            end
            chk("first_load", joyLd[0], 0);
        end

        // Vector table on the GAP=64 scanner, one entry per scan.
        for (int v = 0; v < 13; v++) begin
            pressed[0] = tbl[v].p;
            wait_done(0, "tbl_timeout");
            chk($sformatf("tbl%0d_joy1", v), joy1[0], tbl[v].j1);
            chk($sformatf("tbl%0d_joy2", v), joy2[0], tbl[v].j2);
        end

        // Reset asserted in SHIFT_HI at k=9 (right after the 10th CK rise).
        wait_done(0, "pre_rst_timeout");
        pressed[0] = 16'h0480;
        begin
            int n = 0;
            int guard = 0;
            logic pck = joyCk[0];
            while (n < 10 && guard < 500) begin
                @(negedge clock);
                guard++;
                if (joyCk[0] && !pck) n++;
                pck = joyCk[0];
            end
            chk("reach_k9", n, 10);
            chk("k9_ck_high", joyCk[0], 1);
        end
        reset_n = 1'b0;
        #1;
        chk("async_joyCk", joyCk[0], 0);
        chk("async_joyLd", joyLd[0], 1);
        chk("async_joy", {joy1[0], joy2[0]}, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wait_done(0, "post_rst_timeout");
        chk("post_rst_scan1", {joy1[0], joy2[0]}, 16'h0000);
        wait_done(0, "post_rst_timeout");
        chk("post_rst_scan2", {joy1[0], joy2[0]}, 16'h0120);

        // GAP=0 instance, all buttons pressed.
        wait_done(1, "nogap_timeout");
        pressed[1] = 16'hFFFF;
        wait_done(1, "nogap_timeout");
        chk("nogap_scan1", {joy1[1], joy2[1]}, 16'h0000);
        wait_done(1, "nogap_timeout");
        chk("nogap_scan2", {joy1[1], joy2[1]}, 16'hFFFF);

        // Random patterns, half the time repeated so the debounce passes.
        repeat (12) begin
            wait_done(0, "rand_timeout");
            if ($urandom_range(0, 1) != 0) pressed[0] = 16'($urandom);
            if ($urandom_range(0, 1) != 0) pressed[1] = 16'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
